// File: rtl/ex_mem_stage_pkg.sv
// Shared types and defaults for the EX->MEM pipeline stage and its skid buffer.
package ex_mem_stage_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_REG_AW = 5;

    localparam logic [DEF_REG_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] alu_out;
        logic [DEF_DATA_W-1:0] store_data;
        logic [DEF_REG_AW-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
    } ex_mem_pkt_t;

    // Occupancy of the 2-entry buffer; FULL means main and skid both hold packets.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_MAIN  = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX-side and MEM-side handshake bundle of ex_mem_stage.
// EX_MEM_BNE_EN adds the ex_branch_ne input.
interface ex_mem_stage_if
    import ex_mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned REG_AW = DEF_REG_AW
);

    logic              ex_valid;
    logic              ex_ready;
    logic [DATA_W-1:0] ex_alu_out;
    logic              ex_zero;
    logic [DATA_W-1:0] ex_store_data;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_branch;
    logic [DATA_W-1:0] ex_branch_target;
`ifdef EX_MEM_BNE_EN
    logic              ex_branch_ne;
`endif
    logic              flush;

    logic              mem_valid;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_alu_out;
    logic [DATA_W-1:0] mem_store_data;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_reg_write;
    logic              mem_mem_read;
    logic              mem_mem_write;

    logic              branch_taken;
    logic [DATA_W-1:0] branch_target;

    modport slave (
`ifdef EX_MEM_BNE_EN
        input  ex_branch_ne,
`endif
        input  ex_valid, ex_alu_out, ex_zero, ex_store_data, ex_rd,
        input  ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_branch_target,
        input  flush, mem_ready,
        output ex_ready, mem_valid, mem_alu_out, mem_store_data, mem_rd,
        output mem_reg_write, mem_mem_read, mem_mem_write,
        output branch_taken, branch_target
    );

    modport master (
`ifdef EX_MEM_BNE_EN
        output ex_branch_ne,
`endif
        output ex_valid, ex_alu_out, ex_zero, ex_store_data, ex_rd,
        output ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_branch_target,
        output flush, mem_ready,
        input  ex_ready, mem_valid, mem_alu_out, mem_store_data, mem_rd,
        input  mem_reg_write, mem_mem_read, mem_mem_write,
        input  branch_taken, branch_target
    );

endinterface

// File: rtl/ex_mem_stage_skid_buffer.sv
// Two-entry (main + skid) valid/ready buffer over ex_mem_pkt_t.
// in_ready_o is a pure function of registered occupancy.
module ex_mem_stage_skid_buffer
    import ex_mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  ex_mem_pkt_t in_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output ex_mem_pkt_t out_data_o
);

    buf_state_e  state_q, state_d;
    ex_mem_pkt_t main_q, main_d;
    ex_mem_pkt_t skid_q, skid_d;
    logic        push;
    logic        pop;

    assign in_ready_o  = (state_q != BUF_FULL);
    assign out_valid_o = (state_q != BUF_EMPTY);
    assign out_data_o  = main_q;

    assign push = in_valid_i && in_ready_o;
    assign pop  = out_valid_o && out_ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BUF_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        // Flush leaves the data registers untouched so invalid outputs stay stable.
        if (flush_i) begin
            state_d = BUF_EMPTY;
        end else begin
            unique case (state_q)
                BUF_EMPTY: begin
                    if (push) begin
                        main_d  = in_data_i;
                        state_d = BUF_MAIN;
                    end
                end
                BUF_MAIN: begin
                    if (push && pop) begin
                        main_d = in_data_i;
                    end else if (push) begin
                        skid_d  = in_data_i;
                        state_d = BUF_FULL;
                    end else if (pop) begin
                        state_d = BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    if (pop) begin
                        main_d  = skid_q;
                        state_d = BUF_MAIN;
                        if (push) begin
                            skid_d  = in_data_i;
                            state_d = BUF_FULL;
                        end
                    end
                end
                default: state_d = BUF_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline stage: skid-buffered packet register, branch resolution, r0 masking.
// Define EX_MEM_BNE_EN to resolve bne via ex_branch_ne as well as beq.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned REG_AW = DEF_REG_AW
)
(
    input  logic           clk,
    input  logic           reset,
    ex_mem_stage_if.slave  bus
);

    logic              accept;
    logic              taken_cond;
    logic              buf_in_valid;
    logic              buf_in_ready;
    logic              buf_out_valid;
    logic [REG_AW-1:0] ex_rd;
    ex_mem_pkt_t       in_pkt;
    ex_mem_pkt_t       out_pkt;

    logic              branch_taken_q, branch_taken_d;
    logic [DATA_W-1:0] branch_target_q, branch_target_d;

    assign accept = bus.ex_valid && buf_in_ready;
    assign ex_rd  = bus.ex_rd;

`ifdef EX_MEM_BNE_EN
    assign taken_cond = bus.ex_zero ^ bus.ex_branch_ne;
`else
    assign taken_cond = bus.ex_zero;
`endif

    always_comb begin
        in_pkt            = '0;
        in_pkt.alu_out    = bus.ex_alu_out;
        in_pkt.store_data = bus.ex_store_data;
        in_pkt.rd         = ex_rd;
        in_pkt.reg_write  = bus.ex_reg_write && (ex_rd != REG_ZERO);
        in_pkt.mem_read   = bus.ex_mem_read;
        in_pkt.mem_write  = bus.ex_mem_write;
    end

    // Branches are consumed here and never occupy a buffer entry.
    assign buf_in_valid = bus.ex_valid && !bus.ex_branch && !bus.flush;

    ex_mem_stage_skid_buffer u_skid (
        .clk         (clk),
        .rst         (reset),
        .flush_i     (bus.flush),
        .in_valid_i  (buf_in_valid),
        .in_ready_o  (buf_in_ready),
        .in_data_i   (in_pkt),
        .out_valid_o (buf_out_valid),
        .out_ready_i (bus.mem_ready),
        .out_data_o  (out_pkt)
    );

    always_comb begin
        branch_taken_d  = 1'b0;
        branch_target_d = branch_target_q;
        if (!bus.flush && accept && bus.ex_branch) begin
            branch_taken_d  = taken_cond;
            branch_target_d = bus.ex_branch_target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_taken_q  <= 1'b0;
            branch_target_q <= '0;
        end else begin
            branch_taken_q  <= branch_taken_d;
            branch_target_q <= branch_target_d;
        end
    end

    assign bus.ex_ready       = buf_in_ready;
    assign bus.mem_valid      = buf_out_valid;
    assign bus.mem_alu_out    = out_pkt.alu_out;
    assign bus.mem_store_data = out_pkt.store_data;
    assign bus.mem_rd         = out_pkt.rd;
    assign bus.mem_reg_write  = out_pkt.reg_write;
    assign bus.mem_mem_read   = out_pkt.mem_read;
    assign bus.mem_mem_write  = out_pkt.mem_write;
    assign bus.branch_taken   = branch_taken_q;
    assign bus.branch_target  = branch_target_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus randomized traffic
// compared every cycle against a queue-based model of the stage.
module tb_ex_mem_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    typedef struct {
        logic [DW-1:0] alu;
        logic [DW-1:0] sd;
        logic [AW-1:0] rd;
        logic          rw;
        logic          mr;
        logic          mw;
    } exp_pkt_t;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;
    logic cmp_en;

    ex_mem_stage_if #(.DATA_W(DW), .REG_AW(AW)) bus ();

    ex_mem_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", nm, act, exp, $time);
        end
    endfunction

    // Model: a FIFO of at most two packets; ready means fewer than two held.
    exp_pkt_t      mq[$];
    exp_pkt_t      shown;
    exp_pkt_t      m_new;
    logic          exp_bt;
    logic [DW-1:0] exp_tgt;
    logic          ex_done;
    logic          m_acc;
    logic          m_pop;
    logic          m_taken;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            shown   = '{default: '0};
            exp_bt  = 1'b0;
            exp_tgt = '0;
            ex_done = 1'b1;
        end else begin
            m_acc   = bus.ex_valid && (mq.size() < 2);
            m_pop   = (mq.size() > 0) && bus.mem_ready;
`ifdef EX_MEM_BNE_EN
            m_taken = bus.ex_zero ^ bus.ex_branch_ne;
`else
            m_taken = bus.ex_zero;
`endif
            ex_done = m_acc || bus.flush || !bus.ex_valid;
            exp_bt  = 1'b0;
            if (bus.flush) begin
                mq.delete();
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_acc && bus.ex_branch) begin
                    exp_bt  = m_taken;
                    exp_tgt = bus.ex_branch_target;
                end else if (m_acc) begin
                    m_new.alu = bus.ex_alu_out;
                    m_new.sd  = bus.ex_store_data;
                    m_new.rd  = bus.ex_rd;
                    m_new.rw  = bus.ex_reg_write && (bus.ex_rd != 0);
                    m_new.mr  = bus.ex_mem_read;
                    m_new.mw  = bus.ex_mem_write;
                    mq.push_back(m_new);
                end
            end
            if (mq.size() > 0) shown = mq[0];
        end
    end

    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            check("mem_valid", DW'(bus.mem_valid), DW'(mq.size() > 0));
            check("ex_ready", DW'(bus.ex_ready), DW'(mq.size() < 2));
            check("mem_alu_out", bus.mem_alu_out, shown.alu);
            check("mem_store_data", bus.mem_store_data, shown.sd);
            check("mem_rd", DW'(bus.mem_rd), DW'(shown.rd));
            check("mem_reg_write", DW'(bus.mem_reg_write), DW'(shown.rw));
            check("mem_mem_read", DW'(bus.mem_mem_read), DW'(shown.mr));
            check("mem_mem_write", DW'(bus.mem_mem_write), DW'(shown.mw));
            check("branch_taken", DW'(bus.branch_taken), DW'(exp_bt));
            if (exp_bt) check("branch_target", bus.branch_target, exp_tgt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [DW-1:0] alu, input logic [AW-1:0] rd,
                       input logic rw, input logic br, input logic z, input logic [DW-1:0] tgt);
        bus.ex_valid         = v;
        bus.ex_alu_out       = alu;
        bus.ex_store_data    = alu ^ 32'hA5A5_0000;
        bus.ex_rd            = rd;
        bus.ex_reg_write     = rw;
        bus.ex_mem_read      = 1'b0;
        bus.ex_mem_write     = 1'b0;
        bus.ex_branch        = br;
        bus.ex_zero          = z;
        bus.ex_branch_target = tgt;
`ifdef EX_MEM_BNE_EN
        bus.ex_branch_ne     = 1'b0;
`endif
    endtask

    task automatic idle();
        put(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        cmp_en = 1'b0;
        reset  = 1'b0;
        idle();
        bus.flush     = 1'b0;
        bus.mem_ready = 1'b1;
        #1 reset = 1'b1;
        #10;
        check("rst_mem_valid", DW'(bus.mem_valid), 0);
        check("rst_ex_ready", DW'(bus.ex_ready), 1);
        check("rst_branch_taken", DW'(bus.branch_taken), 0);
        check("rst_mem_alu_out", bus.mem_alu_out, 0);
        #2 reset = 1'b0;
        tick();
        cmp_en = 1'b1;

        // Streaming, mem_ready held high
        for (int unsigned i = 1; i <= 4; i++) begin
            put(1'b1, DW'(i * 16), AW'(i), 1'b1, 1'b0, 1'b0, '0);
            tick();
            check("stream_valid", DW'(bus.mem_valid), 1);
            check("stream_alu", bus.mem_alu_out, DW'(i * 16));
            check("stream_ready", DW'(bus.ex_ready), 1);
        end
        check("stream_store", bus.mem_store_data, 32'hA5A5_0040);
        idle();
        tick();
        check("stream_drained", DW'(bus.mem_valid), 0);

        // Back-pressure: three stalled edges, then release
        bus.mem_ready = 1'b0;
        put(1'b1, 32'h10, 5'd1, 1'b1, 1'b0, 1'b0, '0);
        tick();
        put(1'b1, 32'h20, 5'd2, 1'b1, 1'b0, 1'b0, '0);
        tick();
        check("bp_full_ready", DW'(bus.ex_ready), 0);
        check("bp_full_alu", bus.mem_alu_out, 32'h10);
        put(1'b1, 32'h30, 5'd3, 1'b1, 1'b0, 1'b0, '0);
        tick();
        check("bp_hold_ready", DW'(bus.ex_ready), 0);
        check("bp_hold_alu", bus.mem_alu_out, 32'h10);
        bus.mem_ready = 1'b1;
        tick();
        check("bp_rel1_alu", bus.mem_alu_out, 32'h20);
        check("bp_rel1_ready", DW'(bus.ex_ready), 1);
        tick();
        check("bp_rel2_alu", bus.mem_alu_out, 32'h30);
        check("bp_rel2_valid", DW'(bus.mem_valid), 1);
        idle();
        tick();
        check("bp_drained", DW'(bus.mem_valid), 0);

        // Branch taken / not taken
        put(1'b1, '0, '0, 1'b0, 1'b1, 1'b1, 32'h0040_0100);
        tick();
        check("br_taken", DW'(bus.branch_taken), 1);
        check("br_target", bus.branch_target, 32'h0040_0100);
        check("br_no_valid", DW'(bus.mem_valid), 0);
        idle();
        tick();
        check("br_pulse_end", DW'(bus.branch_taken), 0);
        put(1'b1, '0, '0, 1'b0, 1'b1, 1'b0, 32'h0040_0100);
        tick();
        check("br_not_taken", DW'(bus.branch_taken), 0);
        check("br_nt_no_valid", DW'(bus.mem_valid), 0);
        idle();
        tick();

        // Writes to r0 are masked
        put(1'b1, 32'hDEAD_BEEF, 5'd0, 1'b1, 1'b0, 1'b0, '0);
        tick();
        check("r0_valid", DW'(bus.mem_valid), 1);
        check("r0_reg_write", DW'(bus.mem_reg_write), 0);
        check("r0_alu", bus.mem_alu_out, 32'hDEAD_BEEF);
        idle();
        tick();

        // Flush with both entries full and a taken branch presented
        bus.mem_ready = 1'b0;
        put(1'b1, 32'h51, 5'd4, 1'b1, 1'b0, 1'b0, '0);
        tick();
        put(1'b1, 32'h52, 5'd5, 1'b1, 1'b0, 1'b0, '0);
        tick();
        put(1'b1, '0, '0, 1'b0, 1'b1, 1'b1, 32'h0000_0200);
        bus.flush = 1'b1;
        tick();
        check("fl_valid", DW'(bus.mem_valid), 0);
        check("fl_branch", DW'(bus.branch_taken), 0);
        check("fl_ready", DW'(bus.ex_ready), 1);
        bus.flush = 1'b0;
        idle();
        bus.mem_ready = 1'b1;
        tick();

        // Asynchronous reset while stalled
        bus.mem_ready = 1'b0;
        put(1'b1, 32'h0A01, 5'd6, 1'b1, 1'b0, 1'b0, '0);
        tick();
        put(1'b1, 32'h0A02, 5'd7, 1'b1, 1'b0, 1'b0, '0);
        tick();
        tick();
        check("ar_pre_ready", DW'(bus.ex_ready), 0);
        #2 reset = 1'b1;
        #1;
        check("ar_valid", DW'(bus.mem_valid), 0);
        check("ar_ready", DW'(bus.ex_ready), 1);
        check("ar_branch", DW'(bus.branch_taken), 0);
        check("ar_alu", bus.mem_alu_out, 0);
        check("ar_store", bus.mem_store_data, 0);
        check("ar_rd", DW'(bus.mem_rd), 0);
        check("ar_ctrl", DW'({bus.mem_reg_write, bus.mem_mem_read, bus.mem_mem_write}), 0);
        idle();
        bus.mem_ready = 1'b1;
        #3 reset = 1'b0;
        tick();

        // Randomized traffic; EX holds a packet until it is accepted or flushed
        for (int unsigned c = 0; c < 3000; c++) begin
            bus.mem_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 39) == 0);
            if (ex_done) begin
                bus.ex_valid         = ($urandom_range(0, 9) < 7);
                bus.ex_alu_out       = $urandom();
                bus.ex_store_data    = $urandom();
                bus.ex_rd            = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom());
                bus.ex_reg_write     = 1'($urandom_range(0, 1));
                bus.ex_mem_read      = 1'($urandom_range(0, 1));
                bus.ex_mem_write     = 1'($urandom_range(0, 1));
                bus.ex_branch        = ($urandom_range(0, 4) == 0);
                bus.ex_zero          = 1'($urandom_range(0, 1));
                bus.ex_branch_target = $urandom();
`ifdef EX_MEM_BNE_EN
                bus.ex_branch_ne     = 1'($urandom_range(0, 1));
`endif
            end
            tick();
        end
        bus.flush = 1'b0;
        idle();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
